// File: rtl/interrupt_request_unit.sv
// Interrupt request unit: latches rising-edge requests, masks them, and dispatches the lowest
// unmasked index as an Int pulse. Define INT_TIMEOUT_EN to enable the SERVICE watchdog.
module interrupt_request_unit #(
    parameter int NUM_SRC        = 4,
    parameter int ID_W           = 2,
    parameter int PULSE_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               rti_done,
    output logic               Int,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CNT_W = 4;

    if (NUM_SRC < 2 || NUM_SRC > 16 || ID_W != $clog2(NUM_SRC) ||
        PULSE_CYCLES < 1 || PULSE_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("interrupt_request_unit: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_SERVICE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               int_q, int_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    sel_id;

`ifdef INT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            terr_q, terr_d;
`endif

    always_comb begin
        rise       = irq_in & ~irq_prev_q;
        eligible   = pending_q & ~mask;
        irq_prev_d = irq_in;

        // Scanning downwards leaves the lowest set index as the final winner.
        sel_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end

        clr      = '0;
        state_d  = state_q;
        int_d    = int_q;
        int_id_d = int_id_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
`ifdef INT_TIMEOUT_EN
        wd_d   = wd_q;
        terr_d = terr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    clr      = NUM_SRC'(1) << sel_id;
                    int_id_d = sel_id;
                    int_d    = 1'b1;
                    cnt_d    = CNT_W'(PULSE_CYCLES - 1);
                    busy_d   = 1'b1;
                    state_d  = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    int_d   = 1'b0;
                    state_d = ST_SERVICE;
`ifdef INT_TIMEOUT_EN
                    wd_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SERVICE: begin
                int_d = 1'b0;
                if (rti_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef INT_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh edge wins over the dispatch clear on the same bit.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge Clk) begin
        irq_prev_q <= irq_prev_d;
        if (Rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            int_q     <= 1'b0;
            int_id_q  <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef INT_TIMEOUT_EN
            wd_q   <= '0;
            terr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            int_q     <= int_d;
            int_id_q  <= int_id_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef INT_TIMEOUT_EN
            wd_q   <= wd_d;
            terr_q <= terr_d;
`endif
        end
    end

    assign Int     = int_q;
    assign int_id  = int_id_q;
    assign pending = pending_q;
    assign busy    = busy_q;

`ifdef INT_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
